game_sequencer: RTL
===================

Name: game_sequencer

Overview:
Top-level play controller for the 16x16 LED bird game. It sequences game phases (idle, ready countdown, play, game over) and generates the timing enables that advance the pipe scroller and bird gravity. It accepts the one-cycle score and game-end pulses from the collision/score detector and keeps a 3-digit BCD score. Difficulty rises with score by shortening the scroll period.

Parameters:
TICK_DIV, 25000000, clk cycles per base game tick; minimum 2
SCROLL_INIT, 8, base ticks per pipe-scroll step at level 0
SCROLL_MIN, 2, floor on scroll period in base ticks; 1 <= SCROLL_MIN <= SCROLL_INIT
LEVEL_STEP, 5, points per speed-up; scroll period decrements by 1 each LEVEL_STEP points
GRAV_PERIOD, 3, base ticks per bird fall step
READY_TICKS, 4, base ticks spent in READY before PLAY

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high; acts on the next rising clk edge
start  in  1  one-cycle pulse (debounced key) to start or restart
flap  in  1  one-cycle pulse (debounced key) for a bird flap
score_in  in  1  one-cycle pulse: bird passed a pipe
game_end  in  1  one-cycle pulse: collision or empty pipe field
state  out  2  game_state_t: IDLE=0, READY=1, PLAY=2, OVER=3
clear_board  out  1  one-cycle pulse telling scroller/bird to reinitialise
scroll_tick  out  1  one-cycle pulse: shift pipes one column
fall_tick  out  1  one-cycle pulse: bird moves down one row
flap_out  out  1  one-cycle pulse: bird moves up
score_bcd  out  12  three BCD digits [11:8] hundreds, [7:4] tens, [3:0] ones

Behaviour:
- Reset: state=IDLE; score_bcd=0; scroll period=SCROLL_INIT; all pulse outputs 0; prescaler, scroll, gravity and ready counters 0.
- Prescaler counts clk cycles only in READY and PLAY, and holds at 0 in IDLE and OVER. It asserts internal base_tick for one cycle when the count reaches TICK_DIV-1, then wraps to 0.
- IDLE: start moves to READY and asserts clear_board in the same cycle as the transition edge, so clear_board is registered high for 1 cycle. score_bcd clears to 0 and scroll period reloads SCROLL_INIT on that edge.
- READY: counts base_ticks. After READY_TICKS ticks, moves to PLAY. flap, score_in and game_end are ignored.
- PLAY:
  - scroll counter counts base_ticks. scroll_tick pulses when the counter reaches period-1, then wraps.
  - gravity counter works the same way with GRAV_PERIOD and drives fall_tick.
  - flap: flap_out is registered, 1 cycle after flap. The gravity counter resets to 0 on the same edge, so there is no fall in the same cycle as a flap. flap and a fall due in the same cycle: flap wins and fall_tick is suppressed.
  - score_in: score_bcd increments by 1, with BCD carry, saturating at 999. When the new score is a nonzero multiple of LEVEL_STEP, period = max(period-1, SCROLL_MIN). The new period takes effect at the next wrap.
  - game_end: move to OVER. If game_end and score_in arrive in the same cycle, game_end wins and the score is not incremented.
- OVER: all tick outputs 0 and score_bcd frozen. start moves to IDLE, then a second start is needed to play.
- start in READY or PLAY is ignored.
- Pulse outputs are registered and high for exactly 1 cycle. They never assert outside PLAY, except clear_board.
- Reset mid-game: all outputs reach their reset values on the next edge, regardless of pending pulses.

Optional Feature:
- Macro: GAME_SEQ_HISCORE_EN.
- Defined: adds output hiscore_bcd (12 bits), reset to 0. On the PLAY->OVER edge, if score_bcd > hiscore_bcd (compared as unsigned BCD), hiscore_bcd is loaded with score_bcd. hiscore_bcd is retained across games and cleared only by reset.
- Undefined: the port and register are absent.

Decomposition:
- game_pkg:
  - typedef enum logic[1:0] game_state_t {IDLE, READY, PLAY, OVER}
  - typedef logic[3:0] bcd_digit_t
  - localparam BCD_MAX = 12'h999
- Sub-module bcd_counter3: synchronous clear, increment enable, saturating 3-digit BCD, outputs the count and a "multiple of LEVEL_STEP" flag computed via a side binary counter.

Test Plan:
All scenarios use TICK_DIV=4, SCROLL_INIT=4, SCROLL_MIN=2, LEVEL_STEP=2, GRAV_PERIOD=3, READY_TICKS=2.
1. Reset, then start pulse -> clear_board=1 for 1 cycle; state READY; state PLAY after 8 cycles; first scroll_tick 16 cycles after PLAY entry.
2. In PLAY, 4 score_in pulses -> score_bcd=0x004; scroll period steps 4->3 after score 2 and 3->2 after score 4; a 6th score leaves it at 2; scroll_tick spacing measured at 8 cycles.
3. flap asserted on the cycle a fall is due -> flap_out 1 cycle later, no fall_tick; next fall_tick 12 cycles after the flap.
4. game_end and score_in in the same cycle with score 0x009 -> state OVER, score stays 0x009, no further ticks; start -> IDLE; start -> READY with score 0x000.
5. Force score to 0x999, then score_in -> score stays 0x999. Reset asserted mid-PLAY -> next edge state IDLE, all outputs 0.
6. With GAME_SEQ_HISCORE_EN defined: games scoring 0x012 then 0x007 -> hiscore_bcd=0x012 after both; reset -> 0x000.

Source files
------------

// File: rtl/game_pkg.sv
// Shared types and constants for the LED bird game sequencer.
package game_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READY = 2'd1,
        PLAY  = 2'd2,
        OVER  = 2'd3
    } game_state_t;

    typedef logic [3:0] bcd_digit_t;

    localparam logic [11:0] BCD_MAX = 12'h999;

    // Increment one BCD digit; bit 4 of the result is the carry into the next digit.
    function automatic logic [4:0] bcdDigitInc(input bcd_digit_t d);
        logic [4:0] res;
        if (d == 4'd9) begin
            res = 5'b1_0000;
        end else begin
            res = {1'b0, d + 4'd1};
        end
        return res;
    endfunction

endpackage

// File: rtl/bcd_counter3.sv
// Three-digit saturating BCD score counter. A side binary counter tracks the
// score modulo LEVEL_STEP so the sequencer knows when a speed-up is earned.
module bcd_counter3
    import game_pkg::*;
#(
    parameter int LEVEL_STEP = 5
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_clear,
    input  logic        i_inc,
    output logic [11:0] o_count,
    output logic        o_stepHit
);

    localparam int MW = (LEVEL_STEP > 1) ? $clog2(LEVEL_STEP) : 1;
    localparam logic [MW-1:0] MOD_LAST = MW'(LEVEL_STEP - 1);

    logic [11:0]   r_count;
    logic [MW-1:0] r_modCnt;
    logic [11:0]   w_next;
    logic [4:0]    w_ones;
    logic [4:0]    w_tens;
    logic          w_canInc;

    // Score holds at 999, so the increment is simply refused there.
    assign w_canInc  = i_inc && (r_count != BCD_MAX);
    // This increment lands the score on a nonzero multiple of LEVEL_STEP.
    assign o_stepHit = w_canInc && (r_modCnt == MOD_LAST);
    assign o_count   = r_count;

    // Ripple the +1 through the digits; hundreds never overflow because of saturation.
    always_comb begin
        w_ones = bcdDigitInc(r_count[3:0]);
        w_tens = bcdDigitInc(r_count[7:4]);
        w_next = r_count;
        w_next[3:0] = w_ones[3:0];
        if (w_ones[4]) begin
            w_next[7:4] = w_tens[3:0];
            if (w_tens[4]) begin
                w_next[11:8] = r_count[11:8] + 4'd1;
            end
        end
    end

    // Score register and its modulo shadow move together.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_count  <= '0;
            r_modCnt <= '0;
        end else if (w_canInc) begin
            r_count  <= w_next;
            r_modCnt <= (r_modCnt == MOD_LAST) ? '0 : r_modCnt + MW'(1);
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Play controller for the 16x16 LED bird game: phase FSM, game-tick timing,
// scroll/gravity enables and BCD score with difficulty ramp.
// Optional macro GAME_SEQ_HISCORE_EN adds a retained high-score output.
module game_sequencer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 25000000,
    parameter int SCROLL_INIT = 8,
    parameter int SCROLL_MIN  = 2,
    parameter int LEVEL_STEP  = 5,
    parameter int GRAV_PERIOD = 3,
    parameter int READY_TICKS = 4
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_flap,
    input  logic        i_score_in,
    input  logic        i_game_end,
    output game_state_t o_state,
    output logic        o_clear_board,
    output logic        o_scroll_tick,
    output logic        o_fall_tick,
    output logic        o_flap_out,
    output logic [11:0] o_score_bcd
`ifdef GAME_SEQ_HISCORE_EN
    ,
    output logic [11:0] o_hiscore_bcd
`endif
);

    localparam int PW = $clog2(TICK_DIV);
    localparam int SW = $clog2(SCROLL_INIT + 1);
    localparam int GW = $clog2(GRAV_PERIOD + 1);
    localparam int RW = $clog2(READY_TICKS + 1);
    localparam logic [PW-1:0] PRE_LAST   = PW'(TICK_DIV - 1);
    localparam logic [GW-1:0] GRAV_LAST  = GW'(GRAV_PERIOD - 1);
    localparam logic [RW-1:0] READY_LAST = RW'(READY_TICKS - 1);
    localparam logic [SW-1:0] P_INIT     = SW'(SCROLL_INIT);
    localparam logic [SW-1:0] P_MIN      = SW'(SCROLL_MIN);

    game_state_t r_state;
    logic [PW-1:0] r_preCnt;
    logic [RW-1:0] r_readyCnt;
    logic [SW-1:0] r_scrollCnt;
    logic [SW-1:0] r_period;
    logic [SW-1:0] r_nextPeriod;
    logic [GW-1:0] r_gravCnt;
    logic          r_clearBoard;
    logic          r_scrollTick;
    logic          r_fallTick;
    logic          r_flapOut;

    logic          w_running;
    logic          w_inPlay;
    logic          w_stay;
    logic          w_baseTick;
    logic          w_scrollDue;
    logic          w_fallDue;
    logic          w_gameEnd;
    logic          w_scoreInc;
    logic          w_startIdle;
    logic          w_stepHit;
    logic [SW-1:0] w_periodDec;
    logic [11:0]   w_score;

    assign w_running   = (r_state == READY) || (r_state == PLAY);
    assign w_inPlay    = (r_state == PLAY);
    assign w_gameEnd   = w_inPlay && i_game_end;
    assign w_stay      = w_inPlay && !i_game_end;
    assign w_baseTick  = w_running && (r_preCnt == PRE_LAST);
    assign w_scrollDue = w_inPlay && w_baseTick && (r_scrollCnt == r_period - SW'(1));
    assign w_fallDue   = w_inPlay && w_baseTick && (r_gravCnt == GRAV_LAST);
    assign w_scoreInc  = w_inPlay && i_score_in && !i_game_end;
    assign w_startIdle = (r_state == IDLE) && i_start;
    assign w_periodDec = (r_nextPeriod > P_MIN) ? (r_nextPeriod - SW'(1)) : P_MIN;

    bcd_counter3 #(
        .LEVEL_STEP (LEVEL_STEP)
    ) u_score (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_clear   (w_startIdle),
        .i_inc     (w_scoreInc),
        .o_count   (w_score),
        .o_stepHit (w_stepHit)
    );

    // Base-tick prescaler: runs only while a game is live, parked at 0 otherwise.
    always_ff @(posedge i_clk) begin
        if (i_reset || !w_running || w_gameEnd || w_baseTick) begin
            r_preCnt <= '0;
        end else begin
            r_preCnt <= r_preCnt + PW'(1);
        end
    end

    // Phase FSM with the READY countdown.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= IDLE;
            r_readyCnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_readyCnt <= '0;
                    if (i_start) r_state <= READY;
                end
                READY: begin
                    if (w_baseTick) begin
                        if (r_readyCnt == READY_LAST) begin
                            r_readyCnt <= '0;
                            r_state    <= PLAY;
                        end else begin
                            r_readyCnt <= r_readyCnt + RW'(1);
                        end
                    end
                end
                PLAY: begin
                    if (i_game_end) r_state <= OVER;
                end
                OVER: begin
                    if (i_start) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Scroll counter and period; a speed-up is staged in r_nextPeriod until the next wrap.
    always_ff @(posedge i_clk) begin
        if (i_reset || w_startIdle) begin
            r_scrollCnt  <= '0;
            r_period     <= P_INIT;
            r_nextPeriod <= P_INIT;
        end else if (!w_inPlay) begin
            r_scrollCnt <= '0;
        end else begin
            if (w_stepHit) r_nextPeriod <= w_periodDec;
            if (w_scrollDue) begin
                r_scrollCnt <= '0;
                r_period    <= w_stepHit ? w_periodDec : r_nextPeriod;
            end else if (w_baseTick) begin
                r_scrollCnt <= r_scrollCnt + SW'(1);
            end
        end
    end

    // Gravity counter; a flap restarts the fall interval.
    always_ff @(posedge i_clk) begin
        if (i_reset || !w_inPlay || i_flap) begin
            r_gravCnt <= '0;
        end else if (w_baseTick) begin
            r_gravCnt <= (r_gravCnt == GRAV_LAST) ? '0 : r_gravCnt + GW'(1);
        end
    end

    // Registered one-cycle pulses; a flap beats a fall due on the same edge.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_clearBoard <= 1'b0;
            r_scrollTick <= 1'b0;
            r_fallTick   <= 1'b0;
            r_flapOut    <= 1'b0;
        end else begin
            r_clearBoard <= w_startIdle;
            r_scrollTick <= w_scrollDue && w_stay;
            r_fallTick   <= w_fallDue && w_stay && !i_flap;
            r_flapOut    <= i_flap && w_stay;
        end
    end

`ifdef GAME_SEQ_HISCORE_EN
    logic [11:0] r_hiscore;

    // Capture a new best score as the game ends; packed BCD orders like binary.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_hiscore <= '0;
        end else if (w_gameEnd && (w_score > r_hiscore)) begin
            r_hiscore <= w_score;
        end
    end

    assign o_hiscore_bcd = r_hiscore;
`endif

    assign o_state       = r_state;
    assign o_clear_board = r_clearBoard;
    assign o_scroll_tick = r_scrollTick;
    assign o_fall_tick   = r_fallTick;
    assign o_flap_out    = r_flapOut;
    assign o_score_bcd   = w_score;

endmodule
